// File: rtl/wb_trace_buffer_if.sv
// Writeback trace bus: the pipeline writeback strobe on one side and the
// first-word fall-through read port of the trace FIFO on the other.
interface wb_trace_buffer_if;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic [15:0] rd_seq;

    // Producer/consumer side (pipeline plus trace reader)
    modport master (
        output wb_en, wb_rd, wb_data, rd_ready,
        input  rd_valid, rd_rd, rd_data, rd_seq
    );

    // Trace buffer side
    modport slave (
        input  wb_en, wb_rd, wb_data, rd_ready,
        output rd_valid, rd_rd, rd_data, rd_seq
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures {rd, data, seq} of every register-file
// writeback (except r0) while enabled, into a fall-through FIFO. seq and
// retire_cnt advance even for dropped events so a reader can spot gaps.
module wb_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trc_enable,
    input  logic                    clr_ovf,
    wb_trace_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [31:0]             retire_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] seq;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   seq_q, seq_d;
    logic [31:0]   retire_q, retire_d;
    entry_t        mem_q [DEPTH];
    entry_t        head;

    logic eligible, full, pop, drop, push;

    // Classify this cycle's event: capture, drop, and read-side pop
    always_comb begin
        eligible = bus.wb_en && (bus.wb_rd != 5'd0) && (state_q == RUN);
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && bus.rd_ready;
        // A pop in the same cycle frees a slot, so a full FIFO only drops
        // when nothing is being read out.
        drop     = eligible && full && !pop;
        push     = eligible && !drop;
    end

    // Next-state logic for capture FSM, pointers, occupancy and counters
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        seq_d    = seq_q;
        retire_d = retire_q;

        case (state_q)
            IDLE: if (trc_enable) state_d = RUN;
            RUN: begin
                if (!trc_enable)                state_d = IDLE;
                else if (drop && STOP_ON_FULL)  state_d = HALT;
            end
            HALT: if (!trc_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (eligible) begin
            seq_d    = seq_q + 16'd1;
            retire_d = retire_q + 32'd1;
        end

        // A drop in the same cycle as a clear keeps the flag set
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // Control and counter registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            seq_q    <= seq_d;
            retire_q <= retire_d;
        end
    end

    // Entry storage; contents are left unreset, occupancy guards validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {bus.wb_rd, bus.wb_data, seq_q};
    end

    assign head         = mem_q[rptr_q];
    assign bus.rd_valid = (count_q != '0);
    assign bus.rd_rd    = head.rd;
    assign bus.rd_data  = head.data;
    assign bus.rd_seq   = head.seq;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign retire_cnt   = retire_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a vector table for basic capture/pop behaviour,
// a queue-based reference model for fill/drop/drain/reset sequences, and a
// hand-written sequence for the stop-on-full instance.
`timescale 1ns/1ps
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] seq;
    } ent_t;

    typedef struct {
        logic        en;
        logic [4:0]  r;
        logic [31:0] d;
        logic        rdy;
        logic [4:0]  e_cnt;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [15:0] e_seq;
        logic [31:0] e_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trc, trc_h, clr, clr_h;
    logic [4:0]  count, count_h;
    logic        ovf, ovf_h;
    logic [31:0] ret, ret_h;

    int n_chk  = 0;
    int n_fail = 0;

    ent_t        sb[$];
    logic [15:0] m_seq;
    logic [31:0] m_ret;
    logic        m_ovf;
    logic        m_run;

    wb_trace_buffer_if bus_m();
    wb_trace_buffer_if bus_h();

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dut (
        .clk(clk), .rst(rst), .trc_enable(trc), .clr_ovf(clr), .bus(bus_m),
        .count(count), .overflow(ovf), .retire_cnt(ret)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) dut_h (
        .clk(clk), .rst(rst), .trc_enable(trc_h), .clr_ovf(clr_h), .bus(bus_h),
        .count(count_h), .overflow(ovf_h), .retire_cnt(ret_h)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(sb.size()));
        chk("rd_valid", 32'(bus_m.rd_valid), 32'(sb.size() != 0));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("retire_cnt", ret, m_ret);
        if (sb.size() != 0) begin
            chk("head_rd", 32'(bus_m.rd_rd), 32'(sb[0].rd));
            chk("head_data", bus_m.rd_data, sb[0].data);
            chk("head_seq", 32'(bus_m.rd_seq), 32'(sb[0].seq));
        end
    endtask

    // One clock of the main instance, with the reference model advanced alongside
    task automatic cyc(input logic en, input logic [4:0] r, input logic [31:0] d,
                       input logic rdy, input logic c);
        logic elig, pop, drop;
        bus_m.wb_en    = en;
        bus_m.wb_rd    = r;
        bus_m.wb_data  = d;
        bus_m.rd_ready = rdy;
        clr            = c;
        elig = en && (r != 5'd0) && m_run;
        pop  = rdy && (sb.size() != 0);
        drop = elig && (sb.size() == DEPTH) && !pop;
        if (pop) void'(sb.pop_front());
        if (elig && !drop) sb.push_back('{rd: r, data: d, seq: m_seq});
        if (elig) begin
            m_seq = m_seq + 16'd1;
            m_ret = m_ret + 32'd1;
        end
        if (drop)   m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_run = trc;
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    // One clock of the stop-on-full instance
    task automatic hcyc(input logic en, input logic [4:0] r, input logic [31:0] d, input logic rdy);
        bus_h.wb_en    = en;
        bus_h.wb_rd    = r;
        bus_h.wb_data  = d;
        bus_h.rd_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [13];
        logic [31:0] ret_saved;

        rst = 1'b0; trc = 1'b0; trc_h = 1'b0; clr = 1'b0; clr_h = 1'b0;
        bus_m.wb_en = 1'b0; bus_m.wb_rd = '0; bus_m.wb_data = '0; bus_m.rd_ready = 1'b0;
        bus_h.wb_en = 1'b0; bus_h.wb_rd = '0; bus_h.wb_data = '0; bus_h.rd_ready = 1'b0;

        //            en    r      d              rdy   cnt   e_rd   e_data         e_seq  e_ret
        tbl[0]  = '{1'b1, 5'd8,  32'h0000_00AA, 1'b0, 5'd1, 5'd8,  32'h0000_00AA, 16'd0, 32'd1};
        tbl[1]  = '{1'b1, 5'd9,  32'h1234_5678, 1'b0, 5'd2, 5'd8,  32'h0000_00AA, 16'd0, 32'd2};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[4]  = '{1'b1, 5'd0,  32'h0000_0001, 1'b0, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[5]  = '{1'b1, 5'd0,  32'h0000_0002, 1'b0, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[6]  = '{1'b1, 5'd0,  32'h0000_0003, 1'b0, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[7]  = '{1'b1, 5'd0,  32'h0000_0004, 1'b0, 5'd1, 5'd9,  32'h1234_5678, 16'd1, 32'd2};
        tbl[8]  = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 5'd1, 5'd31, 32'hDEAD_BEEF, 16'd2, 32'd3};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 5'd0,  32'h0,         16'd0, 32'd3};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 5'd0,  32'h0,         16'd0, 32'd3};
        tbl[11] = '{1'b1, 5'd5,  32'h0000_0055, 1'b1, 5'd1, 5'd5,  32'h0000_0055, 16'd3, 32'd4};
        tbl[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 5'd0,  32'h0,         16'd0, 32'd4};

        repeat (3) @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(bus_m.rd_valid), 32'd0);
        chk("reset_overflow", 32'(ovf), 32'd0);
        chk("reset_retire", ret, 32'd0);
        chk("reset_count_h", 32'(count_h), 32'd0);
        chk("reset_retire_h", ret_h, 32'd0);

        // Vector table: release, one edge to enter RUN, then the rows
        rst = 1'b1;
        trc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            bus_m.wb_en    = tbl[i].en;
            bus_m.wb_rd    = tbl[i].r;
            bus_m.wb_data  = tbl[i].d;
            bus_m.rd_ready = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
            chk("tbl_valid", 32'(bus_m.rd_valid), 32'(tbl[i].e_cnt != 5'd0));
            chk("tbl_retire", ret, tbl[i].e_ret);
            chk("tbl_overflow", 32'(ovf), 32'd0);
            if (tbl[i].e_cnt != 5'd0) begin
                chk("tbl_rd", 32'(bus_m.rd_rd), 32'(tbl[i].e_rd));
                chk("tbl_data", bus_m.rd_data, tbl[i].e_data);
                chk("tbl_seq", 32'(bus_m.rd_seq), 32'(tbl[i].e_seq));
            end
        end

        // Scoreboard phase from a clean reset
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        m_seq = '0; m_ret = '0; m_ovf = 1'b0; m_run = 1'b0;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Fill past full: 16 stored, 2 dropped
        for (int i = 0; i < 18; i++) cyc(1'b1, 5'(1 + i % 31), $urandom, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_overflow", 32'(ovf), 32'd1);
        chk("full_retire", ret, 32'd18);

        // Drain returns seq 0..15 in order; next capture is stamped 18
        for (int i = 0; i < 16; i++) begin
            chk("drain_seq", 32'(bus_m.rd_seq), 32'(i));
            cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        chk("drained_valid", 32'(bus_m.rd_valid), 32'd0);
        cyc(1'b1, 5'd7, 32'h0000_0777, 1'b0, 1'b0);
        chk("seq_after_gap", 32'(bus_m.rd_seq), 32'd18);

        // Refill, then push and pop together while full
        for (int i = 0; i < 15; i++) cyc(1'b1, 5'(2 + i), $urandom, 1'b0, 1'b0);
        cyc(1'b1, 5'd30, 32'hA5A5_0001, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(count), 32'd16);
        chk("full_pushpop_ovf", 32'(ovf), 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        cyc(1'b1, 5'd3, 32'hBAD0_0003, 1'b0, 1'b1);
        chk("drop_beats_clr", 32'(ovf), 32'd1);

        // Disable: captures stop, stored entries stay readable
        trc = 1'b0;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        ret_saved = ret;
        cyc(1'b1, 5'd3, 32'h0000_0333, 1'b0, 1'b0);
        chk("idle_retire_frozen", ret, ret_saved);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("idle_count", 32'(count), 32'd13);

        // Re-enable, drain, store 7, then reset in the middle of a cycle
        trc = 1'b1;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH && sb.size() != 0; k++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 5'(10 + i), $urandom, 1'b0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_valid", 32'(bus_m.rd_valid), 32'd0);
        chk("async_reset_ovf", 32'(ovf), 32'd0);
        sb.delete();
        m_seq = '0; m_ret = '0; m_ovf = 1'b0; m_run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 5'd12, 32'h0000_CAFE, 1'b0, 1'b0);
        chk("seq_after_reset", 32'(bus_m.rd_seq), 32'd0);
        chk("rd_after_reset", 32'(bus_m.rd_rd), 32'd12);

        // Stop-on-full instance
        trc_h = 1'b1;
        hcyc(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 17; i++) hcyc(1'b1, 5'(1 + i % 31), 32'(i), 1'b0);
        chk("halt_count", 32'(count_h), 32'd16);
        chk("halt_overflow", 32'(ovf_h), 32'd1);
        chk("halt_retire", ret_h, 32'd17);
        for (int i = 0; i < 3; i++) hcyc(1'b1, 5'd2, 32'h0000_0002, 1'b0);
        chk("halt_retire_frozen", ret_h, 32'd17);
        chk("halt_count_frozen", 32'(count_h), 32'd16);
        trc_h = 1'b0;
        hcyc(1'b0, 5'd0, 32'd0, 1'b0);
        trc_h = 1'b1;
        hcyc(1'b0, 5'd0, 32'd0, 1'b0);
        hcyc(1'b0, 5'd0, 32'd0, 1'b1);
        chk("resume_pop_count", 32'(count_h), 32'd15);
        hcyc(1'b1, 5'd4, 32'h0000_0044, 1'b0);
        chk("resume_count", 32'(count_h), 32'd16);
        chk("resume_retire", ret_h, 32'd18);
        for (int i = 1; i < 16; i++) begin
            chk("resume_drain_seq", 32'(bus_h.rd_seq), 32'(i));
            hcyc(1'b0, 5'd0, 32'd0, 1'b1);
        end
        chk("resume_entry_seq", 32'(bus_h.rd_seq), 32'd17);
        chk("resume_entry_rd", 32'(bus_h.rd_rd), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
